// File: rtl/adc_mcp3002_responder_if.sv
// SPI pad bundle between an MCP3002-style master and the responder.
interface adc_mcp3002_responder_if;
    logic ADC_CLK;
    logic ADC_CS;
    logic ADC_Din;
    logic ADC_Dout;
    logic ADC_Dout_oe;

    modport master (output ADC_CLK, output ADC_CS, output ADC_Din,
                    input  ADC_Dout, input ADC_Dout_oe);
    modport slave  (input  ADC_CLK, input ADC_CS, input ADC_Din,
                    output ADC_Dout, output ADC_Dout_oe);
endinterface

// File: rtl/adc_mcp3002_responder.sv
// MCP3002 emulator: oversamples the SPI pins in clk and answers commands
// with ch0/ch1 codes (single-ended or clamped differential).
module adc_mcp3002_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    adc_mcp3002_responder_if.slave        adc,
    input  logic [9:0]                    ch0_data,
    input  logic [9:0]                    ch1_data,
    output logic [9:0]                    sample_out,
    output logic [2:0]                    cfg_out,
    output logic                          busy,
    output logic                          conv_done,
    output logic                          framing_err
);

    typedef enum logic [3:0] {
        IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF,
        NULL_BIT, DATA_MSB, DATA_LSB, TRAIL
    } state_t;

    function automatic logic [9:0] clamp_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[10] ? 10'd0 : d[9:0];
    endfunction

    function automatic logic [9:0] sel_code(input logic sgl, input logic odd,
                                            input logic [9:0] c0, input logic [9:0] c1);
        if (sgl) return odd ? c1 : c0;
        return odd ? clamp_diff(c1, c0) : clamp_diff(c0, c1);
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q, cs_sync_q, din_sync_q;
    logic                   sclk_prev_q;
    logic                   s_clk, s_cs, s_din, rise, fall;

    state_t     state_q, state_d;
    logic [9:0] code_q, code_d;
    logic       sgl_q, sgl_d, odd_q, odd_d, msbf_q, msbf_d;
    logic       got_msbf_q, got_msbf_d;
    logic [3:0] idx_q, idx_d;
    logic       dout_q, dout_d, oe_q, oe_d;
    logic [9:0] sample_q, sample_d;
    logic [2:0] cfg_q, cfg_d;
    logic       cdone_q, cdone_d, ferr_q, ferr_d;

    assign s_clk = clk_sync_q[SYNC_STAGES-1];
    assign s_cs  = cs_sync_q[SYNC_STAGES-1];
    assign s_din = din_sync_q[SYNC_STAGES-1];
    assign rise  = s_clk & ~sclk_prev_q;
    assign fall  = ~s_clk & sclk_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            cs_sync_q   <= '0;
            din_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], adc.ADC_CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc.ADC_CS};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], adc.ADC_Din};
            sclk_prev_q <= s_clk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            code_q     <= '0;
            sgl_q      <= 1'b0;
            odd_q      <= 1'b0;
            msbf_q     <= 1'b0;
            got_msbf_q <= 1'b0;
            idx_q      <= '0;
            dout_q     <= 1'b0;
            oe_q       <= 1'b0;
            sample_q   <= '0;
            cfg_q      <= '0;
            cdone_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            sgl_q      <= sgl_d;
            odd_q      <= odd_d;
            msbf_q     <= msbf_d;
            got_msbf_q <= got_msbf_d;
            idx_q      <= idx_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            sample_q   <= sample_d;
            cfg_q      <= cfg_d;
            cdone_q    <= cdone_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        sgl_d      = sgl_q;
        odd_d      = odd_q;
        msbf_d     = msbf_q;
        got_msbf_d = got_msbf_q;
        idx_d      = idx_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        sample_d   = sample_q;
        cfg_d      = cfg_q;
        cdone_d    = 1'b0;
        ferr_d     = 1'b0;

        // CS release aborts from any active state; only mid-command/data counts as an error.
        if (state_q != IDLE && s_cs) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            dout_d  = 1'b0;
            ferr_d  = (state_q == GET_SGL)  || (state_q == GET_ODD)  ||
                      (state_q == GET_MSBF) || (state_q == NULL_BIT) ||
                      (state_q == DATA_MSB) || (state_q == DATA_LSB);
        end else begin
            case (state_q)
                IDLE: if (!s_cs) begin
                    state_d = WAIT_START;
                    oe_d    = 1'b1;
                    dout_d  = 1'b0;
                end
                WAIT_START: if (rise && s_din) state_d = GET_SGL;
                GET_SGL: if (rise) begin
                    sgl_d   = s_din;
                    state_d = GET_ODD;
                end
                GET_ODD: if (rise) begin
                    odd_d      = s_din;
                    code_d     = sel_code(sgl_q, s_din, ch0_data, ch1_data);
                    got_msbf_d = 1'b0;
                    state_d    = GET_MSBF;
                end
                GET_MSBF: begin
                    // The fall between ODD and MSBF arrives first and must be skipped.
                    if (rise && !got_msbf_q) begin
                        msbf_d     = s_din;
                        got_msbf_d = 1'b1;
                        cfg_d      = {sgl_q, odd_q, s_din};
                    end else if (fall && got_msbf_q) begin
                        dout_d  = 1'b0;
                        state_d = NULL_BIT;
                    end
                end
                NULL_BIT: if (fall) begin
                    dout_d  = code_q[9];
                    idx_d   = 4'd8;
                    state_d = DATA_MSB;
                end
                DATA_MSB: if (fall) begin
                    dout_d = code_q[idx_q];
                    if (idx_q == 4'd0) begin
                        sample_d = code_q;
                        cdone_d  = msbf_q;
                        idx_d    = 4'd1;
                        state_d  = msbf_q ? TRAIL : DATA_LSB;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
                DATA_LSB: if (fall) begin
                    dout_d = code_q[idx_q];
                    if (idx_q == 4'd9) begin
                        cdone_d = 1'b1;
                        state_d = TRAIL;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                TRAIL: if (fall) dout_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    assign adc.ADC_Dout    = dout_q;
    assign adc.ADC_Dout_oe = oe_q;
    assign sample_out      = sample_q;
    assign cfg_out         = cfg_q;
    assign busy            = (state_q != IDLE);
    assign conv_done       = cdone_q;
    assign framing_err     = ferr_q;

endmodule

// File: tb/tb_adc_mcp3002_responder.sv
// Directed bench acting as the SPI master for adc_mcp3002_responder.
module tb_adc_mcp3002_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] ch0_data = '0, ch1_data = '0;
    logic [9:0] sample_out;
    logic [2:0] cfg_out;
    logic       busy, conv_done, framing_err;

    int total = 0;
    int bad   = 0;
    int cd_cnt = 0;
    int fe_cnt = 0;

    adc_mcp3002_responder_if bus ();

    adc_mcp3002_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc        (bus),
        .ch0_data   (ch0_data),
        .ch1_data   (ch1_data),
        .sample_out (sample_out),
        .cfg_out    (cfg_out),
        .busy       (busy),
        .conv_done  (conv_done),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_done)   cd_cnt++;
        if (framing_err) fe_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI mode-0 bit: Din set while CLK low, Dout sampled just before the rise.
    task automatic clk_bit(input logic din, output logic dout);
        @(negedge clk);
        bus.ADC_Din = din;
        wait_cyc(HALF);
        dout = bus.ADC_Dout;
        bus.ADC_CLK = 1'b1;
        wait_cyc(HALF);
        bus.ADC_CLK = 1'b0;
    endtask

    task automatic cs_low();
        wait_cyc(4);
        bus.ADC_CS = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        bus.ADC_CS = 1'b1;
        wait_cyc(8);
    endtask

    task automatic send_cmd(input logic s, input logic o, input logic m);
        logic d;
        clk_bit(1'b1, d);
        clk_bit(s, d);
        clk_bit(o, d);
        clk_bit(m, d);
    endtask

    task automatic read_bits(input int n, output logic [19:0] r);
        logic b;
        r = '0;
        for (int i = 0; i < n; i++) begin
            clk_bit(1'b0, b);
            r = {r[18:0], b};
        end
    endtask

    task automatic test_reset();
        bus.ADC_CLK = 1'b0; bus.ADC_CS = 1'b1; bus.ADC_Din = 1'b0;
        rst_n = 1'b0;
        wait_cyc(3);
        total++;
        if ({bus.ADC_Dout, bus.ADC_Dout_oe, busy, conv_done, framing_err, sample_out, cfg_out} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus.ADC_Dout, bus.ADC_Dout_oe, busy, conv_done, framing_err, sample_out, cfg_out});
        end
        rst_n = 1'b1;
        wait_cyc(10);
        total++;
        if ({busy, bus.ADC_Dout_oe} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle got=%b want=00", {busy, bus.ADC_Dout_oe});
        end
    endtask

    task automatic test_msbf();
        logic [19:0] r;
        int cd0, fe0;
        ch0_data = 10'h2A5; ch1_data = 10'h0FF;
        cd0 = cd_cnt; fe0 = fe_cnt;
        cs_low();
        total++;
        if ({busy, bus.ADC_Dout_oe, bus.ADC_Dout} !== 3'b110) begin
            bad++;
            $display("FAIL msbf_cs_low got=%b want=110", {busy, bus.ADC_Dout_oe, bus.ADC_Dout});
        end
        send_cmd(1'b1, 1'b0, 1'b1);
        ch0_data = 10'h000;
        read_bits(11, r);
        total++;
        if (r[10:0] !== {1'b0, 10'h2A5}) begin
            bad++;
            $display("FAIL msbf_dout got=%h want=%h", r[10:0], {1'b0, 10'h2A5});
        end
        total++;
        if (cd_cnt - cd0 !== 1) begin
            bad++;
            $display("FAIL msbf_conv_done got=%0d want=1", cd_cnt - cd0);
        end
        total++;
        if ({sample_out, cfg_out} !== {10'h2A5, 3'b101}) begin
            bad++;
            $display("FAIL msbf_sample_cfg got=%h/%b want=2a5/101", sample_out, cfg_out);
        end
        cs_high();
        total++;
        if ({busy, bus.ADC_Dout_oe, fe_cnt - fe0 == 0} !== 3'b001) begin
            bad++;
            $display("FAIL msbf_release got busy=%b oe=%b ferr=%0d want 0 0 0",
                     busy, bus.ADC_Dout_oe, fe_cnt - fe0);
        end
    endtask

    task automatic test_lsb();
        logic [19:0] r, r2;
        int cd0;
        ch0_data = 10'h2A5; ch1_data = 10'h0FF;
        cd0 = cd_cnt;
        cs_low();
        send_cmd(1'b1, 1'b0, 1'b0);
        read_bits(11, r);
        total++;
        if (cd_cnt - cd0 !== 0) begin
            bad++;
            $display("FAIL lsb_early_done got=%0d want=0", cd_cnt - cd0);
        end
        read_bits(9, r2);
        total++;
        if ({r[10:0], r2[8:0]} !== {1'b0, 10'h2A5, 9'b010010101}) begin
            bad++;
            $display("FAIL lsb_dout got=%h want=%h", {r[10:0], r2[8:0]}, {1'b0, 10'h2A5, 9'b010010101});
        end
        total++;
        if ({cd_cnt - cd0 == 1, sample_out, cfg_out} !== {1'b1, 10'h2A5, 3'b100}) begin
            bad++;
            $display("FAIL lsb_done_cfg got cd=%0d sample=%h cfg=%b want 1 2a5 100",
                     cd_cnt - cd0, sample_out, cfg_out);
        end
        cs_high();
    endtask

    task automatic test_diff();
        logic [19:0] r;
        ch0_data = 10'h100; ch1_data = 10'h180;
        cs_low();
        send_cmd(1'b0, 1'b0, 1'b1);
        read_bits(11, r);
        cs_high();
        total++;
        if ({r[10:0], sample_out, cfg_out} !== {11'h000, 10'h000, 3'b001}) begin
            bad++;
            $display("FAIL diff_clamp got bits=%h sample=%h cfg=%b want 000 000 001",
                     r[10:0], sample_out, cfg_out);
        end
        cs_low();
        send_cmd(1'b0, 1'b1, 1'b1);
        read_bits(11, r);
        cs_high();
        total++;
        if ({r[10:0], sample_out, cfg_out} !== {1'b0, 10'h080, 10'h080, 3'b011}) begin
            bad++;
            $display("FAIL diff_pos got bits=%h sample=%h cfg=%b want 080 080 011",
                     r[10:0], sample_out, cfg_out);
        end
    endtask

    task automatic test_start_wait();
        logic [19:0] r;
        logic d;
        ch0_data = 10'h2A5; ch1_data = 10'h0FF;
        cs_low();
        for (int i = 0; i < 5; i++) clk_bit(1'b0, d);
        total++;
        if (cfg_out !== 3'b011) begin
            bad++;
            $display("FAIL wait_no_capture cfg got=%b want=011", cfg_out);
        end
        send_cmd(1'b1, 1'b1, 1'b1);
        read_bits(11, r);
        cs_high();
        total++;
        if ({r[10:0], sample_out} !== {1'b0, 10'h0FF, 10'h0FF}) begin
            bad++;
            $display("FAIL wait_frame got bits=%h sample=%h want 0ff 0ff", r[10:0], sample_out);
        end
    endtask

    task automatic test_framing();
        logic [19:0] r;
        int cd0, fe0;
        ch0_data = 10'h2A5; ch1_data = 10'h155;
        cd0 = cd_cnt; fe0 = fe_cnt;
        cs_low();
        send_cmd(1'b1, 1'b0, 1'b1);
        read_bits(6, r);
        total++;
        if (r[5:0] !== 6'b010101) begin
            bad++;
            $display("FAIL abort_partial got=%b want=010101", r[5:0]);
        end
        cs_high();
        total++;
        if ({fe_cnt - fe0 == 1, cd_cnt - cd0 == 0, bus.ADC_Dout_oe, busy, sample_out} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 10'h0FF}) begin
            bad++;
            $display("FAIL abort_state got ferr=%0d cd=%0d oe=%b busy=%b sample=%h want 1 0 0 0 0ff",
                     fe_cnt - fe0, cd_cnt - cd0, bus.ADC_Dout_oe, busy, sample_out);
        end
        cs_low();
        send_cmd(1'b1, 1'b1, 1'b1);
        read_bits(11, r);
        cs_high();
        total++;
        if ({r[10:0], sample_out} !== {1'b0, 10'h155, 10'h155}) begin
            bad++;
            $display("FAIL abort_next got bits=%h sample=%h want 155 155", r[10:0], sample_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] r;
        int fe0;
        ch0_data = 10'h3C3; ch1_data = 10'h155;
        cs_low();
        send_cmd(1'b1, 1'b0, 1'b1);
        read_bits(4, r);
        fe0 = fe_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ADC_Dout, bus.ADC_Dout_oe, busy, conv_done, framing_err, sample_out, cfg_out} !== 18'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {bus.ADC_Dout, bus.ADC_Dout_oe, busy, conv_done, framing_err, sample_out, cfg_out});
        end
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(8);
        total++;
        if ({busy, bus.ADC_Dout_oe, fe_cnt - fe0 == 0} !== 3'b111) begin
            bad++;
            $display("FAIL midreset_wait got busy=%b oe=%b ferr=%0d want 1 1 0",
                     busy, bus.ADC_Dout_oe, fe_cnt - fe0);
        end
        send_cmd(1'b1, 1'b0, 1'b1);
        read_bits(11, r);
        cs_high();
        total++;
        if ({r[10:0], sample_out, cfg_out} !== {1'b0, 10'h3C3, 10'h3C3, 3'b101}) begin
            bad++;
            $display("FAIL midreset_frame got bits=%h sample=%h cfg=%b want 3c3 3c3 101",
                     r[10:0], sample_out, cfg_out);
        end
    endtask

    initial begin
        test_reset();
        test_msbf();
        test_lsb();
        test_diff();
        test_start_wait();
        test_framing();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_mcp3002_responder.md
ADC_MCP3002_RESPONDER -- requirements
Module: adc_mcp3002_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2 (min 2): synchronizer depth on ADC_CLK, ADC_CS and ADC_Din.
REQ-002 The block SHALL have port clk, input, 1: system clock, at least 8x the ADC_CLK frequency.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 The block SHALL have port ADC_CLK, input, 1: serial clock from the SPI master.
REQ-005 The block SHALL have port ADC_CS, input, 1: active-low chip select from the master.
REQ-006 The block SHALL have port ADC_Din, input, 1: command bits from the master.
REQ-007 The block SHALL have port ADC_Dout, output, 1: serial result to the master.
REQ-008 The block SHALL have port ADC_Dout_oe, output, 1: ADC_Dout drive enable; 0 means high-Z at the pad.
REQ-009 The block SHALL have ports ch0_data and ch1_data, input, 10 each: emulated channel codes.
REQ-010 The block SHALL have port sample_out, output, 10: last code returned.
REQ-011 The block SHALL have port cfg_out, output, 3: {SGL/DIFF, ODD/SIGN, MSBF} of the last command.
REQ-012 The block SHALL have port busy, output, 1: high while a frame is in progress.
REQ-013 The block SHALL have port conv_done, output, 1: one-cycle pulse when the final data bit is driven.
REQ-014 The block SHALL have port framing_err, output, 1: one-cycle pulse when CS rises mid-frame.

Function
REQ-015 ADC_CLK, ADC_CS and ADC_Din SHALL each pass through SYNC_STAGES flops in clk.
  - Edges are detected on the synchronized ADC_CLK.
  - All actions occur on the clk cycle after edge detection.
REQ-016 The FSM SHALL have states IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF, NULL_BIT, DATA_MSB, DATA_LSB and TRAIL.
REQ-017 In IDLE, synchronized CS low SHALL move the FSM to WAIT_START.
  - ADC_Dout_oe rises in the same cycle.
  - ADC_Dout drives 0.
REQ-018 In WAIT_START, a rising ADC_CLK edge with Din=1 SHALL be the start bit and move to GET_SGL; Din=0 SHALL leave the FSM in WAIT_START.
REQ-019 The next three rising edges SHALL capture SGL/DIFF, ODD/SIGN and MSBF in that order.
REQ-020 On the rising edge that captures ODD/SIGN, the block SHALL latch the code.
  - SGL=1: code = ODD ? ch1_data : ch0_data.
  - SGL=0, ODD=0: code = ch0_data - ch1_data.
  - SGL=0, ODD=1: code = ch1_data - ch0_data.
  - Differential results are computed at 11 bits and clamp to 0 when negative.
REQ-021 The block SHALL update cfg_out on the MSBF capture.
REQ-022 The first falling ADC_CLK edge after the MSBF capture SHALL drive the null bit (0) and enter NULL_BIT.
REQ-023 The next 10 falling edges SHALL drive B9..B0 (DATA_MSB).
REQ-024 The falling edge that drives B0 SHALL update sample_out, and SHALL pulse conv_done when MSBF=1.
REQ-025 If MSBF=1, the FSM SHALL go to TRAIL after B0.
REQ-026 If MSBF=0, the FSM SHALL go from B0 to DATA_LSB.
  - The next 9 falling edges drive B1..B9.
  - conv_done pulses with B9.
  - The FSM then goes to TRAIL.
REQ-027 In TRAIL, ADC_Dout SHALL drive 0 on every falling edge until CS rises.
REQ-028 A synchronized CS rise in any state SHALL return the FSM to IDLE in that cycle and clear ADC_Dout_oe and busy.
  - framing_err pulses if the state was GET_SGL through DATA_LSB.
  - conv_done does not pulse.
  - sample_out and cfg_out are unchanged.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 A CS fall and a clock edge detected in the same cycle SHALL act on the CS fall only; that clock edge is ignored.
REQ-031 ch0_data and ch1_data changes after the latch SHALL NOT affect the frame in progress.

Reset
REQ-032 While rst_n is low, the block SHALL asynchronously clear all of the following:
  - the FSM to IDLE and all synchronizer flops;
  - ADC_Dout, ADC_Dout_oe, busy, conv_done and framing_err to 0;
  - sample_out and cfg_out to 0.
REQ-033 After rst_n deasserts with CS already low, the block SHALL enter WAIT_START and wait for a start bit; a partial frame SHALL NOT be resumed.

Verification
REQ-034 The bench SHALL cover these scenarios:
  - ch0=0x2A5, ch1=0x0FF, command 1,1,0,1 (start, SGL, CH0, MSBF) -> Dout null, then 1010100101; conv_done once; sample_out=0x2A5; cfg_out=3'b101.
  - Same ch0, command 1,1,0,0 -> Dout null, 1010100101, then 010010101; one conv_done after the last bit.
  - ch0=0x100, ch1=0x180, command 1,0,0,1 -> code 0 (clamped); command 1,0,1,1 -> code 0x080.
  - Din held 0 for 5 clocks, then the start bit -> no early capture; a correct frame follows.
  - CS raised after B5 -> framing_err pulses once; Dout_oe=0; sample_out unchanged; the next frame is correct.
  - rst_n pulsed low during DATA_MSB -> all outputs 0 at once; with CS still low, the next start bit yields a valid frame.
